// File: rtl/alpha_mem_arb.sv
// Two-requester (IF/LS) arbiter sharing the single alpha_miu request/response channel.
// Optional build macro ALPHA_MEM_ARB_RR_EN swaps the LS-priority/starvation scheme for round-robin.

`ifndef PKT_W
`define PKT_W 64
`endif
`ifndef PKT_BITS
`define PKT_BITS 63:0
`endif
`ifndef PKT_VLD
`define PKT_VLD 63
`endif
`ifndef PKT_LAST
`define PKT_LAST 62
`endif
`ifndef PKT_SIZE
`define PKT_SIZE 61:60
`endif
`ifndef PKT_WE
`define PKT_WE 59
`endif
`ifndef PKT_ADDR
`define PKT_ADDR 55:32
`endif
`ifndef PKT_DATA
`define PKT_DATA 31:0
`endif
`ifndef REQ_SZ_LINE
`define REQ_SZ_LINE 2'd3
`endif

module alpha_mem_arb #(
    parameter int OUTST      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [`PKT_BITS] if_req_pkt,
    output logic             if_req_ack,
    output logic [`PKT_BITS] if_resp_pkt,
    input  logic [`PKT_BITS] ls_req_pkt,
    output logic             ls_req_ack,
    output logic [`PKT_BITS] ls_resp_pkt,
    output logic [`PKT_BITS] miu_req_pkt,
    input  logic             miu_req_ack,
    input  logic [`PKT_BITS] miu_resp_pkt,
    output logic             resp_err
);

    localparam int AW = (OUTST > 1) ? $clog2(OUTST) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;
    typedef enum logic {OWN_LS = 1'b0, OWN_IF = 1'b1} own_t;

    state_t           state;
    state_t           state_nxt;
    own_t             grant;
    own_t             sel;
    logic             if_vld;
    logic             ls_vld;
    logic [`PKT_BITS] sel_pkt;
    logic             fwd_vld;
    logic             accept;

    logic [AW:0]      count;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    own_t             id_mem [OUTST];
    own_t             head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             resp_vld;
    logic             resp_ok;
    logic             err_q;

`ifdef ALPHA_MEM_ARB_RR_EN
    own_t             last_win;
`else
    logic [3:0]       starve_cnt;
`endif

    // Non-line requests are single-beat, so the MIU must always see LAST on them.
    function automatic logic [`PKT_BITS] force_last(input logic [`PKT_BITS] p);
        logic [`PKT_BITS] r;
        r = p;
        if (p[`PKT_SIZE] != `REQ_SZ_LINE) r[`PKT_LAST] = 1'b1;
        return r;
    endfunction

    assign if_vld = if_req_pkt[`PKT_VLD];
    assign ls_vld = ls_req_pkt[`PKT_VLD];
    assign full   = (count == (AW+1)'(OUTST));
    assign empty  = (count == '0);

    always_comb begin
        sel = OWN_LS;
        if (state == S_HOLD) begin
            sel = grant;
        end
`ifdef ALPHA_MEM_ARB_RR_EN
        else if (if_vld && ls_vld) begin
            sel = (last_win == OWN_IF) ? OWN_LS : OWN_IF;
        end
        else if (if_vld) begin
            sel = OWN_IF;
        end
`else
        else if (ls_vld && !(if_vld && starve_cnt == 4'(STARVE_MAX))) begin
            sel = OWN_LS;
        end
        else if (if_vld) begin
            sel = OWN_IF;
        end
`endif
    end

    // A full ID FIFO blocks new requests in IDLE; HOLD can only exist below full.
    assign sel_pkt     = (sel == OWN_IF) ? if_req_pkt : ls_req_pkt;
    assign fwd_vld     = !reset && sel_pkt[`PKT_VLD] && ((state == S_HOLD) || !full);
    assign miu_req_pkt = fwd_vld ? force_last(sel_pkt) : '0;
    assign accept      = miu_req_ack && miu_req_pkt[`PKT_VLD];
    assign if_req_ack  = accept && (sel == OWN_IF);
    assign ls_req_ack  = accept && (sel == OWN_LS);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (fwd_vld && !miu_req_ack) state_nxt = S_HOLD;
            S_HOLD: if (miu_req_ack) state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            grant <= OWN_LS;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && state_nxt == S_HOLD) grant <= sel;
        end
    end

`ifdef ALPHA_MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset)       last_win <= OWN_IF;
        else if (accept) last_win <= sel;
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_vld || if_req_ack) begin
            starve_cnt <= '0;
        end else if (ls_req_ack && starve_cnt != 4'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    // One FIFO entry per accepted request; a line burst pops only on its LAST beat.
    assign resp_vld = miu_resp_pkt[`PKT_VLD];
    assign push     = accept;
    assign pop      = resp_vld && miu_resp_pkt[`PKT_LAST] && !empty;
    assign head     = id_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) id_mem[wr_ptr] <= sel;
    end

    assign resp_ok     = !reset && resp_vld && !empty;
    assign if_resp_pkt = (resp_ok && head == OWN_IF) ? miu_resp_pkt : '0;
    assign ls_resp_pkt = (resp_ok && head == OWN_LS) ? miu_resp_pkt : '0;

    always_ff @(posedge clk) begin
        if (reset)                  err_q <= 1'b0;
        else if (resp_vld && empty) err_q <= 1'b1;
    end

    assign resp_err = err_q && !reset;

    a_one_ack: assert property (@(posedge clk) disable iff (reset) !(if_req_ack && ls_req_ack));
    a_no_ovf:  assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: tb/tb_alpha_mem_arb.sv
// Directed bench for alpha_mem_arb: cycle model with an owner queue plus hand-computed spot checks.
// Honours ALPHA_MEM_ARB_RR_EN for the round-robin variant.

`ifndef PKT_W
`define PKT_W 64
`endif
`ifndef PKT_BITS
`define PKT_BITS 63:0
`endif
`ifndef PKT_VLD
`define PKT_VLD 63
`endif
`ifndef PKT_LAST
`define PKT_LAST 62
`endif
`ifndef PKT_SIZE
`define PKT_SIZE 61:60
`endif
`ifndef PKT_WE
`define PKT_WE 59
`endif
`ifndef PKT_ADDR
`define PKT_ADDR 55:32
`endif
`ifndef PKT_DATA
`define PKT_DATA 31:0
`endif
`ifndef REQ_SZ_LINE
`define REQ_SZ_LINE 2'd3
`endif

module tb_alpha_mem_arb;
    localparam int OUTST = 4;
    localparam int SM    = 3;
    localparam int LS    = 0;
    localparam int IFR   = 1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic        clk;
    logic        reset;
    logic [63:0] if_req_pkt, ls_req_pkt, miu_resp_pkt;
    logic        miu_req_ack;
    logic        if_req_ack, ls_req_ack, resp_err;
    logic [63:0] if_resp_pkt, ls_resp_pkt, miu_req_pkt;

    int checks = 0;
    int errors = 0;

    alpha_mem_arb #(.OUTST(OUTST), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .if_req_pkt(if_req_pkt), .if_req_ack(if_req_ack), .if_resp_pkt(if_resp_pkt),
        .ls_req_pkt(ls_req_pkt), .ls_req_ack(ls_req_ack), .ls_resp_pkt(ls_resp_pkt),
        .miu_req_pkt(miu_req_pkt), .miu_req_ack(miu_req_ack),
        .miu_resp_pkt(miu_resp_pkt), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input logic vld, input logic last, input logic [1:0] sz,
                                       input logic we, input logic [23:0] addr, input logic [31:0] data);
        logic [63:0] p;
        p = '0;
        p[`PKT_VLD]  = vld;
        p[`PKT_LAST] = last;
        p[`PKT_SIZE] = sz;
        p[`PKT_WE]   = we;
        p[`PKT_ADDR] = addr;
        p[`PKT_DATA] = data;
        return p;
    endfunction

    function automatic logic [63:0] fixl(input logic [63:0] p);
        logic [63:0] r;
        r = p;
        if (p[`PKT_SIZE] != `REQ_SZ_LINE) r[`PKT_LAST] = 1'b1;
        return r;
    endfunction

    // Behavioural model: owner queue, held requester, starvation count / last winner.
    int   m_hold = -1;
    int   m_starve = 0;
    int   m_last = IFR;
    int   m_q[$];
    bit   m_err = 1'b0;
    int   c_w;
    bit   c_fwd, c_acc, c_ifv, c_lsv, c_rv, c_rl;
    logic [63:0] c_req, c_ifr, c_lsr, c_wp;

    always @(negedge clk) begin
        c_ifv = if_req_pkt[`PKT_VLD];
        c_lsv = ls_req_pkt[`PKT_VLD];
        c_rv  = miu_resp_pkt[`PKT_VLD];
        c_rl  = miu_resp_pkt[`PKT_LAST];
        c_w   = LS;
        c_fwd = 1'b0;
        c_req = '0; c_ifr = '0; c_lsr = '0;
        if (!reset) begin
            if (m_hold >= 0) begin
                c_w = m_hold;
            end else if (m_q.size() < OUTST) begin
`ifdef ALPHA_MEM_ARB_RR_EN
                if (c_ifv && c_lsv) c_w = (m_last == IFR) ? LS : IFR;
                else                c_w = c_ifv ? IFR : LS;
`else
                if (c_lsv && !(c_ifv && m_starve == SM)) c_w = LS;
                else                                     c_w = c_ifv ? IFR : LS;
`endif
            end
            c_wp  = (c_w == IFR) ? if_req_pkt : ls_req_pkt;
            c_fwd = c_wp[`PKT_VLD] && (m_hold >= 0 || m_q.size() < OUTST);
            if (c_fwd) c_req = fixl(c_wp);
            if (c_rv && m_q.size() > 0) begin
                if (m_q[0] == IFR) c_ifr = miu_resp_pkt;
                else               c_lsr = miu_resp_pkt;
            end
        end
        c_acc = c_fwd && miu_req_ack;
        chk("m_miu_req", miu_req_pkt, c_req);
        chk1("m_if_ack", if_req_ack, c_acc && c_w == IFR);
        chk1("m_ls_ack", ls_req_ack, c_acc && c_w == LS);
        chk("m_if_resp", if_resp_pkt, c_ifr);
        chk("m_ls_resp", ls_resp_pkt, c_lsr);
        chk1("m_resp_err", resp_err, !reset && m_err);
        if (reset) begin
            m_hold = -1; m_starve = 0; m_last = IFR; m_err = 1'b0;
            m_q.delete();
        end else begin
            if (c_rv && m_q.size() == 0) m_err = 1'b1;
            if (c_rv && c_rl && m_q.size() > 0) void'(m_q.pop_front());
            if (c_acc) m_q.push_back(c_w);
            if (m_hold < 0) begin
                if (c_fwd && !miu_req_ack) m_hold = c_w;
            end else if (miu_req_ack) begin
                m_hold = -1;
            end
            if (!c_ifv || (c_acc && c_w == IFR)) m_starve = 0;
            else if (c_acc && m_starve < SM)     m_starve++;
            if (c_acc) m_last = c_w;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    int exp_g[6];
    logic [63:0] pk;

    initial begin
`ifdef ALPHA_MEM_ARB_RR_EN
        exp_g = '{LS, IFR, LS, IFR, LS, IFR};
`else
        exp_g = '{LS, LS, LS, IFR, LS, LS};
`endif
        reset = 1'b1;
        if_req_pkt = '0; miu_resp_pkt = '0; miu_req_ack = 1'b0;
        ls_req_pkt = mk(1, 1, SZ_WORD, 0, 24'h0100, 32'h0);
        miu_req_ack = 1'b1;
        miu_resp_pkt = mk(1, 1, SZ_WORD, 0, 24'h0, 32'h77);
        repeat (2) nxt();
        @(negedge clk);
        chk("rst_miu_req", miu_req_pkt, 64'h0);
        chk1("rst_ls_ack", ls_req_ack, 1'b0);
        chk("rst_ls_resp", ls_resp_pkt, 64'h0);
        chk1("rst_err", resp_err, 1'b0);
        nxt();
        ls_req_pkt = '0; miu_req_ack = 1'b0; miu_resp_pkt = '0;
        reset = 1'b0;

        // IF line fetch acked in the same cycle, two response beats
        if_req_pkt = mk(1, 0, `REQ_SZ_LINE, 0, 24'h1000, 32'h0);
        miu_req_ack = 1'b1;
        @(negedge clk);
        chk1("t1_if_ack", if_req_ack, 1'b1);
        chk("t1_miu_req", miu_req_pkt, mk(1, 0, `REQ_SZ_LINE, 0, 24'h1000, 32'h0));
        nxt();
        if_req_pkt = '0; miu_req_ack = 1'b0;
        miu_resp_pkt = mk(1, 0, `REQ_SZ_LINE, 0, 24'h0, 32'hAAAA0001);
        @(negedge clk);
        chk("t1_if_resp0", if_resp_pkt, mk(1, 0, `REQ_SZ_LINE, 0, 24'h0, 32'hAAAA0001));
        chk("t1_ls_resp0", ls_resp_pkt, 64'h0);
        nxt();
        miu_resp_pkt = mk(1, 1, `REQ_SZ_LINE, 0, 24'h0, 32'hAAAA0002);
        @(negedge clk);
        chk("t1_if_resp1", if_resp_pkt, mk(1, 1, `REQ_SZ_LINE, 0, 24'h0, 32'hAAAA0002));
        nxt();
        miu_resp_pkt = '0;

        // Both valid, ack low 3 cycles: LS held (LAST forced) while IF changes
        ls_req_pkt = mk(1, 0, SZ_WORD, 0, 24'h3000, 32'h0);
        if_req_pkt = mk(1, 1, SZ_WORD, 0, 24'h2000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hold_pkt", miu_req_pkt, mk(1, 1, SZ_WORD, 0, 24'h3000, 32'h0));
            chk1("t2_no_ack", ls_req_ack, 1'b0);
            nxt();
            if_req_pkt = mk(1, 1, SZ_WORD, 0, 24'h2010 + 24'(i * 16), 32'h0);
        end
        miu_req_ack = 1'b1;
        @(negedge clk);
        chk1("t2_ls_ack", ls_req_ack, 1'b1);
        chk1("t2_if_noack", if_req_ack, 1'b0);
        nxt();
        ls_req_pkt = '0;
        @(negedge clk);
        chk1("t2_if_ack", if_req_ack, 1'b1);
        nxt();
        if_req_pkt = '0; miu_req_ack = 1'b0;
        miu_resp_pkt = mk(1, 1, SZ_WORD, 0, 24'h0, 32'h5151);
        @(negedge clk);
        chk("t2_ls_resp", ls_resp_pkt, mk(1, 1, SZ_WORD, 0, 24'h0, 32'h5151));
        chk("t2_if_resp0", if_resp_pkt, 64'h0);
        nxt();
        miu_resp_pkt = mk(1, 1, SZ_WORD, 0, 24'h0, 32'h1F1F);
        @(negedge clk);
        chk("t2_if_resp", if_resp_pkt, mk(1, 1, SZ_WORD, 0, 24'h0, 32'h1F1F));
        chk("t2_ls_resp0", ls_resp_pkt, 64'h0);
        nxt();
        miu_resp_pkt = '0;

        // Grant order with both valid and ack every cycle
        ls_req_pkt = mk(1, 1, SZ_WORD, 1, 24'h4000, 32'h12345678);
        if_req_pkt = mk(1, 1, SZ_WORD, 0, 24'h4100, 32'h0);
        miu_req_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            miu_resp_pkt = (i > 0) ? mk(1, 1, SZ_WORD, 0, 24'h0, 32'(i)) : 64'h0;
            @(negedge clk);
            chk1("t3_grant_if", if_req_ack, exp_g[i] == IFR);
            chk1("t3_grant_ls", ls_req_ack, exp_g[i] == LS);
            nxt();
        end
        ls_req_pkt = '0; if_req_pkt = '0; miu_req_ack = 1'b0;
        miu_resp_pkt = mk(1, 1, SZ_WORD, 0, 24'h0, 32'h66);
        nxt();
        miu_resp_pkt = '0;

        // Fill the ID FIFO, then stall until a response frees a slot
        miu_req_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ls_req_pkt = mk(1, 1, SZ_WORD, 0, 24'h5000 + 24'(i * 4), 32'h0);
            @(negedge clk);
            chk1("t4_fill_ack", ls_req_ack, 1'b1);
            nxt();
        end
        ls_req_pkt = mk(1, 1, SZ_WORD, 0, 24'h5010, 32'h0);
        @(negedge clk);
        chk1("t4_full_vld", miu_req_pkt[`PKT_VLD], 1'b0);
        chk1("t4_full_noack", ls_req_ack, 1'b0);
        nxt();
        miu_resp_pkt = mk(1, 1, SZ_WORD, 0, 24'h0, 32'hD0);
        @(negedge clk);
        chk1("t4_pop_noack", ls_req_ack, 1'b0);
        chk("t4_pop_resp", ls_resp_pkt, mk(1, 1, SZ_WORD, 0, 24'h0, 32'hD0));
        nxt();
        miu_resp_pkt = '0;
        @(negedge clk);
        chk1("t4_fifth_ack", ls_req_ack, 1'b1);
        chk("t4_fifth_pkt", miu_req_pkt, mk(1, 1, SZ_WORD, 0, 24'h5010, 32'h0));
        nxt();
        ls_req_pkt = mk(1, 1, SZ_WORD, 0, 24'h5014, 32'h0);
        miu_resp_pkt = mk(1, 1, SZ_WORD, 0, 24'h0, 32'hD1);
        @(negedge clk);
        chk1("t4_refull_noack", ls_req_ack, 1'b0);
        nxt();
        miu_resp_pkt = mk(1, 1, SZ_WORD, 0, 24'h0, 32'hD2);
        @(negedge clk);
        chk1("t4_pushpop_ack", ls_req_ack, 1'b1);
        chk("t4_pushpop_resp", ls_resp_pkt, mk(1, 1, SZ_WORD, 0, 24'h0, 32'hD2));
        nxt();
        ls_req_pkt = '0; miu_req_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            miu_resp_pkt = mk(1, 1, SZ_WORD, 0, 24'h0, 32'hE0 + 32'(i));
            nxt();
        end
        miu_resp_pkt = '0;

        // Response with nothing outstanding
        miu_resp_pkt = mk(1, 1, SZ_WORD, 0, 24'h0, 32'hEE);
        @(negedge clk);
        chk("t5_if_resp", if_resp_pkt, 64'h0);
        chk("t5_ls_resp", ls_resp_pkt, 64'h0);
        chk1("t5_err_before", resp_err, 1'b0);
        nxt();
        miu_resp_pkt = '0;
        @(negedge clk);
        chk1("t5_err_set", resp_err, 1'b1);
        repeat (3) nxt();
        @(negedge clk);
        chk1("t5_err_sticky", resp_err, 1'b1);

        // Reset while holding an LS request
        nxt();
        ls_req_pkt = mk(1, 1, SZ_WORD, 0, 24'h6000, 32'h0);
        nxt();
        @(negedge clk);
        chk("t6_hold_pkt", miu_req_pkt, mk(1, 1, SZ_WORD, 0, 24'h6000, 32'h0));
        nxt();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_req", miu_req_pkt, 64'h0);
        chk1("t6_rst_err", resp_err, 1'b0);
        nxt();
        ls_req_pkt = '0;
        reset = 1'b0;
        if_req_pkt = mk(1, 1, SZ_WORD, 0, 24'h7000, 32'h0);
        miu_req_ack = 1'b1;
        @(negedge clk);
        chk1("t6_post_if_ack", if_req_ack, 1'b1);
        chk1("t6_post_err", resp_err, 1'b0);
        nxt();
        if_req_pkt = '0; miu_req_ack = 1'b0;
        repeat (2) nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
